// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// The optional DM wait freeze is enabled with PIPE_CTRL_DM_WAIT_EN.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_EXC    = 2'd2,
    PC_ERET   = 2'd3
  } pc_sel_t;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MD_BUSY = 1'b1
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic       read_mem;
    logic       sign_ext;
    logic [1:0] size;
  } load_type_t;

  function automatic logic reg_hit(
    input logic [4:0] dst,
    input logic [4:0] rs,
    input logic [4:0] rt
  );
    return (dst != 5'd0) &&
           ((dst == rs) || (dst == rt));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_stall_counter.sv
// Mul/div occupancy tracker: start pulse, busy state
// and down-counter that holds EXE for N cycles.
module md_stall_counter
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic start,
  input  logic is_div,
  input  logic abort,
  output logic stall,
  output logic busy
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] DIV_LAST =
    CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] MUL_LAST =
    CW'(MUL_CYCLES - 1);

  pipe_ctrl_state_t state;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (!hold) begin
      if (abort) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              cnt   <= is_div ? DIV_LAST
                              : MUL_LAST;
              state <= S_MD_BUSY;
            end
          end
          S_MD_BUSY: begin
            if (cnt == '0)
              state <= S_IDLE;
            else
              cnt <= cnt - CW'(1);
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // The start cycle itself is the first stall cycle.
  assign busy  = (state == S_MD_BUSY);
  assign stall = (state == S_IDLE) ? start
                                   : (cnt != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Define PIPE_CTRL_DM_WAIT_EN to add the DM_Busy freeze input.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
`ifdef PIPE_CTRL_DM_WAIT_EN
  input  logic       DM_Busy,
`endif
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic [4:0] EXE_Dst,
  input  logic [3:0] EXE_LoadType,
  input  logic       EXE_RFWr,
  input  logic       EXE_IsDiv,
  input  logic       EXE_IsMul,
  input  logic       EXE_BranchTaken,
  input  logic       MEM_ExceptValid,
  input  logic       MEM_IsEret,
  output logic       IF_PCWr,
  output logic       IF_IDWr,
  output logic       IFID_Flush,
  output logic       IDEXE_Flush,
  output logic       IDEXE_Wr,
  output logic       EXEMEM_Flush,
  output logic       MEMWB_Wr,
  output logic [1:0] PC_Sel,
  output logic       MD_Start,
  output logic       MD_Abort,
  output logic       MD_Busy
);

  logic dm_busy;
`ifdef PIPE_CTRL_DM_WAIT_EN
  assign dm_busy = DM_Busy;
`else
  assign dm_busy = 1'b0;
`endif

  load_type_t ld;
  logic       unused_ld;
  assign ld        = load_type_t'(EXE_LoadType);
  assign unused_ld = ^{ld.sign_ext, ld.size};

  logic exc;
  logic md_start;
  logic md_stall;
  logic md_busy;
  logic load_use;

  assign exc      = MEM_ExceptValid | MEM_IsEret;
  assign md_start = (EXE_IsDiv | EXE_IsMul) &
                    ~exc & ~dm_busy;
  assign load_use = ld.read_mem & EXE_RFWr &
                    reg_hit(EXE_Dst, ID_rs, ID_rt);

  md_stall_counter #(
    .DIV_CYCLES (DIV_CYCLES),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_md (
    .clk    (clk),
    .rst    (rst),
    .hold   (dm_busy),
    .start  (md_start),
    .is_div (EXE_IsDiv),
    .abort  (exc),
    .stall  (md_stall),
    .busy   (md_busy)
  );

  pc_sel_t pc_sel;

  always_comb begin
    IF_PCWr      = 1'b1;
    IF_IDWr      = 1'b1;
    IFID_Flush   = 1'b0;
    IDEXE_Flush  = 1'b0;
    IDEXE_Wr     = 1'b1;
    EXEMEM_Flush = 1'b0;
    MEMWB_Wr     = 1'b1;
    pc_sel       = PC_SEQ;
    MD_Start     = 1'b0;
    MD_Abort     = 1'b0;
    if (rst) begin
      IF_PCWr      = 1'b0;
      IF_IDWr      = 1'b0;
      IFID_Flush   = 1'b1;
      IDEXE_Flush  = 1'b1;
      IDEXE_Wr     = 1'b0;
      EXEMEM_Flush = 1'b1;
      MEMWB_Wr     = 1'b0;
    end else if (dm_busy) begin
      IF_PCWr  = 1'b0;
      IF_IDWr  = 1'b0;
      IDEXE_Wr = 1'b0;
      MEMWB_Wr = 1'b0;
    end else if (exc) begin
      IFID_Flush   = 1'b1;
      IDEXE_Flush  = 1'b1;
      EXEMEM_Flush = 1'b1;
      pc_sel       = MEM_ExceptValid ? PC_EXC
                                     : PC_ERET;
      MD_Abort     = md_busy;
    end else if (md_stall) begin
      // EXE holds; a bubble goes down to MEM.
      IF_PCWr      = 1'b0;
      IF_IDWr      = 1'b0;
      IDEXE_Wr     = 1'b0;
      EXEMEM_Flush = 1'b1;
      MD_Start     = ~md_busy;
    end else if (EXE_BranchTaken) begin
      pc_sel     = PC_BRANCH;
      IFID_Flush = 1'b1;
    end else if (load_use) begin
      IF_PCWr     = 1'b0;
      IF_IDWr     = 1'b0;
      IDEXE_Flush = 1'b1;
    end
  end

  assign PC_Sel  = pc_sel;
  assign MD_Busy = md_busy & ~rst;

endmodule
